// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one pmem line port between I-side and D-side caches
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DONE} state_t;

  state_t                  state_q, state_d;
  logic                    last_grant_q, last_grant_d;  // 1 = D side granted last
  logic                    pmem_read_q, pmem_read_d;
  logic                    pmem_write_q, pmem_write_d;
  logic [ADDR_WIDTH-1:0]   pmem_address_q, pmem_address_d;
  logic [LINE_WIDTH-1:0]   pmem_wdata_q, pmem_wdata_d;
  logic                    i_req, d_req, grant_i, grant_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      last_grant_q   <= 1'b0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
    end
  end

  // D wins a tie unless it was the last side served.
  always_comb begin
    i_req   = i_read;
    d_req   = d_read | d_write;
    grant_d = (state_q == IDLE) && d_req && (!i_req || !last_grant_q);
    grant_i = (state_q == IDLE) && i_req && !grant_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_d)      state_d = GRANT_D;
        else if (grant_i) state_d = GRANT_I;
      end
      GRANT_I, GRANT_D: if (pmem_resp) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_grant_d   = last_grant_q;
    pmem_read_d    = pmem_read_q;
    pmem_write_d   = pmem_write_q;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;
    if (grant_d) begin
      last_grant_d   = 1'b1;
      pmem_address_d = d_address;
      pmem_wdata_d   = d_wdata;
      pmem_write_d   = d_write;
      pmem_read_d    = !d_write;
    end else if (grant_i) begin
      last_grant_d   = 1'b0;
      pmem_address_d = i_address;
      pmem_read_d    = 1'b1;
      pmem_write_d   = 1'b0;
    end else if ((state_q == GRANT_I || state_q == GRANT_D) && pmem_resp) begin
      pmem_read_d  = 1'b0;
      pmem_write_d = 1'b0;
    end
  end

  always_comb begin
    i_resp       = (state_q == GRANT_I) && pmem_resp;
    d_resp       = (state_q == GRANT_D) && pmem_resp;
    i_rdata      = pmem_rdata;
    d_rdata      = pmem_rdata;
    pmem_read    = pmem_read_q;
    pmem_write   = pmem_write_q;
    pmem_address = pmem_address_q;
    pmem_wdata   = pmem_wdata_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic         i_read, d_read, d_write, pmem_resp;
  logic [31:0]  i_address, d_address;
  logic [255:0] d_wdata, pmem_rdata;
  logic [255:0] i_rdata, d_rdata, pmem_wdata;
  logic         i_resp, d_resp, pmem_read, pmem_write;
  logic [31:0]  pmem_address;
  int           checks = 0;
  int           passed = 0;

  localparam logic [255:0] A5 = {32{8'hA5}};
  localparam logic [255:0] L5A = {32{8'h5A}};
  localparam logic [255:0] C3 = {32{8'hC3}};

  mem_port_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(256)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
    i_address = '0; d_address = '0; d_wdata = '0; pmem_rdata = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_pmem_read", pmem_read, 0);
    chk("rst_pmem_write", pmem_write, 0);
    chk("rst_pmem_address", pmem_address, 0);
    chk("rst_pmem_wdata", pmem_wdata, 0);
    chk("rst_i_resp", i_resp, 0);
    chk("rst_d_resp", d_resp, 0);

    // single I read, memory answers on the third grant cycle
    i_read = 1; i_address = 32'h0000_1040;
    step();
    chk("i1_pmem_read", pmem_read, 1);
    chk("i1_pmem_write", pmem_write, 0);
    chk("i1_addr", pmem_address, 32'h1040);
    chk("i1_no_early_resp", i_resp, 0);
    step(); step();
    chk("i1_hold_read", pmem_read, 1);
    pmem_rdata = A5; pmem_resp = 1; #1;
    chk("i1_i_resp", i_resp, 1);
    chk("i1_i_rdata", i_rdata, A5);
    chk("i1_d_resp", d_resp, 0);
    step();
    pmem_resp = 0; i_read = 0; #1;
    chk("i1_resp_one_cycle", i_resp, 0);
    chk("i1_strobe_clear", pmem_read, 0);
    step();

    // simultaneous requests after reset: D, I, D, I
    rst = 1; step(); rst = 0;
    i_read = 1; i_address = 32'h1000; d_read = 1; d_address = 32'h2000;
    step();
    chk("rr1_addr_d", pmem_address, 32'h2000);
    chk("rr1_read", pmem_read, 1);
    pmem_resp = 1; pmem_rdata = C3; #1;
    chk("rr1_d_resp", d_resp, 1);
    chk("rr1_d_rdata", d_rdata, C3);
    chk("rr1_i_resp", i_resp, 0);
    step(); pmem_resp = 0;
    step();
    chk("rr_idle_no_strobe", pmem_read, 0);
    step();
    chk("rr2_addr_i", pmem_address, 32'h1000);
    pmem_resp = 1; #1;
    chk("rr2_i_resp", i_resp, 1);
    chk("rr2_d_resp", d_resp, 0);
    step(); pmem_resp = 0; step(); step();
    chk("rr3_addr_d", pmem_address, 32'h2000);
    pmem_resp = 1; #1;
    chk("rr3_d_resp", d_resp, 1);
    step(); pmem_resp = 0; step(); step();
    chk("rr4_addr_i", pmem_address, 32'h1000);
    pmem_resp = 1; #1;
    chk("rr4_i_resp", i_resp, 1);
    step(); pmem_resp = 0; i_read = 0; d_read = 0;
    step();

    // read+write together: write wins; address change mid-grant is ignored
    d_read = 1; d_write = 1; d_address = 32'h3000; d_wdata = L5A;
    step();
    chk("wr_pmem_write", pmem_write, 1);
    chk("wr_pmem_read", pmem_read, 0);
    chk("wr_wdata", pmem_wdata, L5A);
    chk("wr_addr", pmem_address, 32'h3000);
    d_address = 32'hFFFF_FFC0;
    step();
    chk("wr_addr_held", pmem_address, 32'h3000);
    pmem_resp = 1; #1;
    chk("wr_d_resp", d_resp, 1);
    step();
    d_read = 0; d_write = 0; #1;
    chk("done_spurious_d", d_resp, 0);
    chk("done_spurious_i", i_resp, 0);
    chk("done_write_clear", pmem_write, 0);
    step();
    chk("idle_spurious_d", d_resp, 0);
    pmem_resp = 0;
    step();

    // reset two cycles into GRANT_I abandons the transaction
    i_read = 1; i_address = 32'h1040;
    step();
    chk("rm_read", pmem_read, 1);
    step(); step();
    rst = 1; i_read = 0;
    step();
    rst = 0;
    chk("rm_read_cleared", pmem_read, 0);
    chk("rm_no_i_resp", i_resp, 0);
    d_read = 1; d_address = 32'h4000;
    step();
    chk("rm_d_read", pmem_read, 1);
    chk("rm_d_addr", pmem_address, 32'h4000);
    pmem_resp = 1; pmem_rdata = A5; #1;
    chk("rm_d_resp", d_resp, 1);
    chk("rm_i_resp", i_resp, 0);
    step(); pmem_resp = 0; d_read = 0;
    step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one physical-memory line port between the instruction-side cache (read-only) and the data-side cache (read/write).
- Sits between the two caches feeding the pipeline datapath and the single pmem/L2 interface.
- Serves one transaction at a time, with round-robin fairness and data-side preference on a tie.
- Latches each granted request so the pmem side stays stable until the memory responds.

Parameters:
- ADDR_WIDTH, 32, physical address width in bits.
- LINE_WIDTH, 256, cache line width in bits.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i_read  in  1  I-side line read request; held until i_resp
- i_address  in  ADDR_WIDTH  I-side line address
- i_rdata  out  LINE_WIDTH  I-side read data; valid only when i_resp=1
- i_resp  out  1  I-side completion pulse, 1 cycle
- d_read  in  1  D-side line read request; held until d_resp
- d_write  in  1  D-side line write (writeback) request; held until d_resp
- d_address  in  ADDR_WIDTH  D-side line address
- d_wdata  in  LINE_WIDTH  D-side write line
- d_rdata  out  LINE_WIDTH  D-side read data; valid only when d_resp=1
- d_resp  out  1  D-side completion pulse, 1 cycle
- pmem_read  out  1  memory read strobe, registered
- pmem_write  out  1  memory write strobe, registered
- pmem_address  out  ADDR_WIDTH  latched request address, registered
- pmem_wdata  out  LINE_WIDTH  latched write line, registered
- pmem_rdata  in  LINE_WIDTH  memory read data
- pmem_resp  in  1  memory completion, 1 cycle

Behaviour:

Reset values (synchronous reset):
- state=IDLE, last_grant=I.
- pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0.
- i_resp=0, d_resp=0.

State machine: states IDLE, GRANT_I, GRANT_D, DONE.
- IDLE: i_req=i_read; d_req=d_read|d_write.
  - Neither pending: stay in IDLE.
  - Only one pending: grant it.
  - Both pending: grant D if last_grant==I, else grant I (round-robin).
  - On grant, at the same edge: latch address (and d_wdata for D); set pmem_read or pmem_write; set last_grant; move to GRANT_x.
- Latency: a request seen in IDLE at cycle N drives the pmem strobe at cycle N+1.
- GRANT_x: hold pmem strobe, address and wdata constant.
  - When pmem_resp=1, the same cycle combinationally assert x_resp=1 and drive x_rdata=pmem_rdata.
  - At that edge, clear the pmem strobes and go to DONE.
- DONE: one dead cycle with no grant and no resp. This lets the requester drop its request, so a stale request is never re-granted. Then go to IDLE.
- Throughput: back-to-back transactions cost response cycle + DONE + IDLE grant cycle.
- i_rdata and d_rdata wire directly to pmem_rdata. Consumers use them only when their resp is high. The non-granted requester's resp is always 0.

Boundary rules:
- d_read and d_write both high: write wins; pmem_write=1, pmem_read=0.
- pmem_read and pmem_write are never high together.
- Requester drops or changes its request mid-grant: this is a protocol violation. The arbiter ignores it and completes the latched transaction; the resp pulse is still issued.
- pmem_resp while in IDLE or DONE: ignored; no resp forwarded.
- A new request arriving on the other side during GRANT_x waits. It is considered in IDLE after DONE.
- Reset mid-transaction: return to IDLE at the edge; strobes are 0 the next cycle; the pending transaction is abandoned with no resp.
- Starvation bound: with both sides always requesting, grants strictly alternate D, I, D, I…

Test Plan:
- Single I read: i_read=1, i_address=0x0000_1040; pmem_resp after 3 cycles with rdata=0xA5…A5.
  - Required: pmem_read=1 with address 0x1040 from the cycle after the request.
  - Required: i_resp=1 for exactly 1 cycle, i_rdata=0xA5…A5; d_resp stays 0.
- Simultaneous first requests: i_read and d_read both set at the same cycle after reset.
  - Required: D served first (address 0x2000), then I (address 0x1000).
  - Required: last_grant alternates; with both held continuously, the grant order is D, I, D, I.
- D read+write both high: d_address=0x3000, d_wdata=0x5A…5A.
  - Required: pmem_write=1 with wdata=0x5A…5A, pmem_read=0, then d_resp=1 for 1 cycle.
- Request perturbation mid-grant: change d_address to 0xFFFF_FFC0 while in GRANT_D.
  - Required: pmem_address stays 0x3000.
  - Required: a spurious pmem_resp in DONE produces no resp.
- Reset mid-op: assert rst 2 cycles into GRANT_I.
  - Required: pmem_read=0 the next cycle, no i_resp, and a fresh d_read is then granted normally.
